// File: rtl/axis_corr_stimgen.sv
// Stimulus generator and result collector for the correlation kernel host streams.
// Drives configurable per-run patterns on m_axis, then counts results on s_axis until a tlast in DRAIN.
module axis_corr_stimgen #(
  parameter int DATA_W = 512,
  parameter int LANE_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 32,
  parameter int RUN_W  = 8
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CNT_W-1:0]    cfg_elements,
  input  logic [LANE_W-1:0]   cfg_seed,
  input  logic [1:0]          cfg_mode,
  input  logic [RUN_W-1:0]    cfg_runs,
  input  logic [DEST_W-1:0]   cfg_dest,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic [DEST_W-1:0]   m_axis_tdest,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic                busy,
  output logic                done,
  output logic [RUN_W-1:0]    run_idx,
  output logic [CNT_W-1:0]    beats_sent,
  output logic [CNT_W-1:0]    results_rcvd,
  output logic [LANE_W-1:0]   last_result
);

  localparam int NL = DATA_W / LANE_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  elements_q, elements_d;
  logic [LANE_W-1:0] seed_q, seed_d;
  logic [1:0]        mode_q, mode_d;
  logic [RUN_W-1:0]  runs_q, runs_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [LANE_W-1:0] value_q, value_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [RUN_W-1:0]  run_idx_q, run_idx_d;
  logic [CNT_W-1:0]  beats_sent_q, beats_sent_d;
  logic [CNT_W-1:0]  results_rcvd_q, results_rcvd_d;
  logic [LANE_W-1:0] last_result_q, last_result_d;

  logic              m_hs, s_hs, cfg_acc, is_last;
  logic [RUN_W:0]    run_nxt;
  logic [DATA_W-1:0] data_pat;
  logic              unused_tdata_hi;

  assign unused_tdata_hi = ^s_axis_tdata[DATA_W-1:LANE_W];

  assign m_axis_tvalid = (state_q == S_STREAM);
  assign m_hs    = m_axis_tvalid & m_axis_tready;
  assign s_hs    = s_axis_tvalid & s_axis_tready;
  assign cfg_acc = (state_q == S_IDLE) & cfg_valid;
  assign is_last = (beat_q == elements_q - CNT_W'(1));
  assign run_nxt = {1'b0, run_idx_q} + (RUN_W+1)'(1);

  always_comb begin
    data_pat = '0;
    for (int i = 0; i < NL; i++) begin
      data_pat[i*LANE_W +: LANE_W] = value_q + ((mode_q == 2'd1) ? LANE_W'(i) : '0);
    end
  end

  always_comb begin
    state_d      = state_q;
    elements_d   = elements_q;
    seed_d       = seed_q;
    mode_d       = mode_q;
    runs_d       = runs_q;
    dest_d       = dest_q;
    value_d      = value_q;
    beat_d       = beat_q;
    run_idx_d    = run_idx_q;
    beats_sent_d = beats_sent_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          elements_d   = cfg_elements;
          seed_d       = cfg_seed;
          mode_d       = cfg_mode;
          runs_d       = (cfg_runs == '0) ? RUN_W'(1) : cfg_runs;
          dest_d       = cfg_dest;
          value_d      = cfg_seed;
          beat_d       = '0;
          run_idx_d    = '0;
          beats_sent_d = '0;
          state_d      = (cfg_elements == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (m_hs) begin
          beat_d       = beat_q + CNT_W'(1);
          beats_sent_d = beats_sent_q + CNT_W'(1);
          case (mode_q)
            2'd0, 2'd1: value_d = value_q + LANE_W'(1);
            2'd3:       value_d = value_q - LANE_W'(1);
            default:    value_d = value_q;
          endcase
          if (is_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Only a result tlast seen here closes the run; earlier ones are just counted.
        if (s_hs && s_axis_tlast) begin
          state_d = (run_nxt < {1'b0, runs_q}) ? S_NEXT : S_DONE;
        end
      end
      S_NEXT: begin
        run_idx_d = run_idx_q + RUN_W'(1);
        value_d   = seed_q;
        beat_d    = '0;
        state_d   = S_STREAM;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    results_rcvd_d = (cfg_acc ? '0 : results_rcvd_q) + (s_hs ? CNT_W'(1) : '0);
    last_result_d  = s_hs ? s_axis_tdata[LANE_W-1:0] : last_result_q;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q        <= S_IDLE;
      elements_q     <= '0;
      seed_q         <= '0;
      mode_q         <= '0;
      runs_q         <= '0;
      dest_q         <= '0;
      value_q        <= '0;
      beat_q         <= '0;
      run_idx_q      <= '0;
      beats_sent_q   <= '0;
      results_rcvd_q <= '0;
      last_result_q  <= '0;
    end else begin
      state_q        <= state_d;
      elements_q     <= elements_d;
      seed_q         <= seed_d;
      mode_q         <= mode_d;
      runs_q         <= runs_d;
      dest_q         <= dest_d;
      value_q        <= value_d;
      beat_q         <= beat_d;
      run_idx_q      <= run_idx_d;
      beats_sent_q   <= beats_sent_d;
      results_rcvd_q <= results_rcvd_d;
      last_result_q  <= last_result_d;
    end
  end

  // Ready outputs are gated by reset so they read low while it is held.
  assign cfg_ready     = (state_q == S_IDLE) & ~ap_rst;
  assign s_axis_tready = ~ap_rst;
  assign m_axis_tdata  = m_axis_tvalid ? data_pat : '0;
  assign m_axis_tkeep  = {(DATA_W/8){m_axis_tvalid}};
  assign m_axis_tdest  = m_axis_tvalid ? dest_q : '0;
  assign m_axis_tlast  = m_axis_tvalid & is_last;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign run_idx       = run_idx_q;
  assign beats_sent    = beats_sent_q;
  assign results_rcvd  = results_rcvd_q;
  assign last_result   = last_result_q;

endmodule

// File: tb/tb_axis_corr_stimgen.sv
// Randomized bench for axis_corr_stimgen: expected beats are generated per config from the
// pattern rules and compared against the stimulus stream on every valid cycle.
module tb_axis_corr_stimgen;

  localparam int DATA_W = 512;
  localparam int LANE_W = 32;
  localparam int NL     = DATA_W / LANE_W;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [31:0]        cfg_elements = '0;
  logic [31:0]        cfg_seed = '0;
  logic [1:0]         cfg_mode = '0;
  logic [7:0]         cfg_runs = '0;
  logic [3:0]         cfg_dest = '0;
  logic [DATA_W-1:0]  m_axis_tdata;
  logic [63:0]        m_axis_tkeep;
  logic [3:0]         m_axis_tdest;
  logic               m_axis_tlast, m_axis_tvalid;
  logic               m_axis_tready = 1'b1;
  logic [DATA_W-1:0]  s_axis_tdata = '0;
  logic               s_axis_tlast = 1'b0, s_axis_tvalid = 1'b0;
  logic               s_axis_tready;
  logic               busy, done;
  logic [7:0]         run_idx;
  logic [31:0]        beats_sent, results_rcvd, last_result;

  axis_corr_stimgen dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_elements(cfg_elements),
    .cfg_seed(cfg_seed), .cfg_mode(cfg_mode), .cfg_runs(cfg_runs), .cfg_dest(cfg_dest),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tdest(m_axis_tdest),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .busy(busy), .done(done), .run_idx(run_idx),
    .beats_sent(beats_sent), .results_rcvd(results_rcvd), .last_result(last_result)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [3:0]        dest;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       acc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          stall_pct = 0;
  int unsigned model_beats = 0;
  int unsigned model_results = 0;
  logic [31:0] model_last = '0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected beats from the pattern rules: lane i of beat k = seed + k*step (+ i in lane-indexed mode).
  function automatic void push_expected(input int unsigned e, input logic [31:0] sd,
                                        input logic [1:0] md, input int rn, input logic [3:0] ds);
    for (int r = 0; r < rn; r++) begin
      for (int unsigned k = 0; k < e; k++) begin
        beat_t b;
        logic [31:0] base;
        case (md)
          2'd0, 2'd1: base = sd + 32'(k);
          2'd3:       base = sd - 32'(k);
          default:    base = sd;
        endcase
        for (int i = 0; i < NL; i++) b.data[i*LANE_W +: LANE_W] = base + ((md == 2'd1) ? 32'(i) : 32'd0);
        b.last = (k == e - 1);
        b.dest = ds;
        exp_q.push_back(b);
      end
    end
  endfunction

  always @(posedge ap_clk) begin
    #1 m_axis_tready = ($urandom_range(0, 99) >= stall_pct);
  end

  // Single compare process; handshakes are predicted at the negedge preceding the capturing edge.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      check("s_tready_high", s_axis_tready, 1);
      check("cfg_ready_vs_busy", cfg_ready, !busy);
      if (done) done_cnt++;
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got tvalid=1 expected no beat at %0t", $time);
        end else begin
          check("tdata", m_axis_tdata, exp_q[0].data);
          check("tlast", m_axis_tlast, exp_q[0].last);
          check("tdest", m_axis_tdest, exp_q[0].dest);
          check("tkeep", m_axis_tkeep, {64{1'b1}});
          if (m_axis_tready) begin
            beat_t b;
            b.data = m_axis_tdata; b.last = m_axis_tlast; b.dest = m_axis_tdest;
            acc_q.push_back(b);
            void'(exp_q.pop_front());
            model_beats++;
          end
        end
      end
      if (s_axis_tvalid) begin
        model_results++;
        model_last = s_axis_tdata[31:0];
      end
    end
  end

  task automatic do_cfg(input int unsigned e, input logic [31:0] sd, input logic [1:0] md,
                        input int rn, input logic [3:0] ds);
    @(posedge ap_clk); #1;
    check("cfg_ready_idle", cfg_ready, 1);
    cfg_elements = e; cfg_seed = sd; cfg_mode = md; cfg_runs = 8'(rn); cfg_dest = ds;
    cfg_valid = 1'b1;
    @(posedge ap_clk); #1;
    cfg_valid = 1'b0;
    model_beats = 0; model_results = 0; done_cnt = 0;
    acc_q.delete();
    push_expected(e, sd, md, (rn == 0) ? 1 : rn, ds);
  endtask

  task automatic wait_beats(input int unsigned n);
    int cyc = 0;
    while (model_beats < n) begin
      @(negedge ap_clk);
      cyc++;
      if (cyc > 3000) begin
        n_cmp++; n_err++;
        $display("FAIL beat_timeout: got %0d beats expected %0d", model_beats, n);
        return;
      end
    end
  endtask

  task automatic send_result(input logic [31:0] v, input logic last);
    @(posedge ap_clk); #1;
    s_axis_tdata = {$urandom, $urandom, $urandom, $urandom, 384'(0), v};
    s_axis_tdata[DATA_W-1 -: 32] = $urandom;
    s_axis_tlast = last; s_axis_tvalid = 1'b1;
    @(posedge ap_clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic finish_runs(input int unsigned e, input int rn);
    for (int r = 0; r < rn; r++) begin
      wait_beats(e * (r + 1));
      repeat (2) @(negedge ap_clk);
      check("drain_busy", busy, 1);
      check("drain_no_valid", m_axis_tvalid, 0);
      check("drain_no_done", done, 0);
      send_result($urandom, 1'b1);
      @(negedge ap_clk);
      if (r == rn - 1) begin
        check("done_pulse", done, 1);
        @(negedge ap_clk);
        check("done_drop", done, 0);
        check("back_idle", cfg_ready, 1);
      end else begin
        check("next_gap_valid", m_axis_tvalid, 0);
        check("next_gap_busy", busy, 1);
        @(negedge ap_clk);
        check("next_restart", m_axis_tvalid, 1);
      end
    end
  endtask

  task automatic end_checks(input int rn);
    check("beats_sent", beats_sent, model_beats);
    check("results_rcvd", results_rcvd, model_results);
    check("last_result", last_result, model_last);
    check("run_idx", run_idx, rn - 1);
    check("queue_empty", exp_q.size(), 0);
    check("one_done", done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ds;
    logic [31:0] sd;
    #12;
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdest", m_axis_tdest, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_counters", {beats_sent, results_rcvd, run_idx, last_result}, 0);
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    check("post_rst_cfg_ready", cfg_ready, 1);

    // Two runs of an incrementing ramp.
    ds = 4'($urandom);
    do_cfg(10, 32'd0, 2'd0, 2, ds);
    @(negedge ap_clk);
    check("first_valid", m_axis_tvalid, 1);
    finish_runs(10, 2);
    end_checks(2);
    check("t1_count", acc_q.size(), 20);
    check("t1_b9_lane0", acc_q[9].data[31:0], 32'd9);
    check("t1_b10_lane0", acc_q[10].data[31:0], 32'd0);
    check("t1_b9_last", acc_q[9].last, 1);
    check("t1_b0_last", acc_q[0].last, 0);
    check("t1_b19_last", acc_q[19].last, 1);
    check("t1_beats_lit", beats_sent, 32'd20);
    check("t1_results_lit", results_rcvd, 32'd2);

    // Lane-indexed mode wrapping across the lane offsets.
    do_cfg(2, 32'hFFFF_FFFE, 2'd1, 1, 4'h3);
    finish_runs(2, 1);
    end_checks(1);
    check("t2_b0_lane15", acc_q[0].data[15*32 +: 32], 32'h0000_000D);
    check("t2_b1_lane0", acc_q[1].data[31:0], 32'hFFFF_FFFF);

    // Decrementing under random backpressure.
    stall_pct = 50;
    do_cfg(100, 32'd5, 2'd3, 1, 4'hA);
    finish_runs(100, 1);
    end_checks(1);
    check("t3_count", acc_q.size(), 100);
    check("t3_b5_lane0", acc_q[5].data[31:0], 32'd0);
    check("t3_b6_lane0", acc_q[6].data[31:0], 32'hFFFF_FFFF);
    check("t3_b99_lane0", acc_q[99].data[31:0], 32'hFFFF_FFA2);
    stall_pct = 0;

    // Zero elements: immediate completion, no beats.
    do_cfg(0, 32'd7, 2'd0, 3, 4'h1);
    @(negedge ap_clk);
    check("t4_done", done, 1);
    check("t4_no_valid", m_axis_tvalid, 0);
    @(negedge ap_clk);
    check("t4_idle", cfg_ready, 1);
    check("t4_beats", beats_sent, 0);

    // Reset in the middle of a run, then a clean restart.
    do_cfg(20, 32'd100, 2'd0, 1, 4'h2);
    wait_beats(4);
    @(posedge ap_clk); #2 ap_rst = 1'b1;
    #1;
    check("t5_rst_valid", m_axis_tvalid, 0);
    check("t5_rst_cfg_ready", cfg_ready, 0);
    check("t5_rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    model_beats = 0; model_results = 0; model_last = '0;
    @(negedge ap_clk);
    check("t5_cfg_ready", cfg_ready, 1);
    check("t5_counters", {beats_sent, results_rcvd, run_idx}, 0);
    sd = $urandom;
    do_cfg(5, sd, 2'd2, 1, 4'h9);
    finish_runs(5, 1);
    end_checks(1);

    // Result tlast arriving during STREAM must not end the run.
    do_cfg(12, 32'h1234, 2'($urandom_range(0, 3)), 1, 4'h4);
    wait_beats(3);
    send_result(32'hCAFE_0001, 1'b1);
    @(negedge ap_clk);
    check("t6_early_counted", results_rcvd, 1);
    finish_runs(12, 1);
    end_checks(1);
    check("t6_results_lit", results_rcvd, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
